// File: rtl/sound_mbox_pkg.sv
// Shared definitions for the 68k <-> sound-CPU mailbox.
//   mbox_state_e : reset-sequencer states (RUN, RST_HOLD)
//   DW           : mailbox data width
//   MST_* / SST_*: bit positions inside main_status / snd_status
package sound_mbox_pkg;
    localparam int DW = 8;

    typedef enum logic {
        RUN      = 1'b0,
        RST_HOLD = 1'b1
    } mbox_state_e;

    // main_status = {rst_busy, s2m_full, m2s_ovf, m2s_full}
    localparam int MST_M2S_FULL = 0;
    localparam int MST_M2S_OVF  = 1;
    localparam int MST_S2M_FULL = 2;
    localparam int MST_RST_BUSY = 3;

    // snd_status = {s2m_ovf, s2m_full, m2s_nonempty}
    localparam int SST_M2S_NONEMPTY = 0;
    localparam int SST_S2M_FULL     = 1;
    localparam int SST_S2M_OVF      = 2;
endpackage

// File: rtl/mbox_fifo.sv
// Synchronous show-ahead FIFO for 68k->sound commands.
// Ports: clk, rst (async, active-high), push/pop strobes, flush (clears
// contents, wins over push/pop), din, dout (head, 0 when empty), full,
// empty, count. Push while full succeeds only together with a pop;
// overflow reporting is left to the parent.
module mbox_fifo
    import sound_mbox_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push+pop on full succeeds.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/sound_mailbox_ctrl.sv
// Command/response mailbox between the main 68k and the 6502 sound CPU.
// 68k side : main_wr/main_din (command push), main_rd/main_dout (response),
//            main_irq, main_snd_rst, main_status.
// Sound side: snd_rd68k/snd_dout (command pop), snd_wr68k/snd_din (response),
//            snd_status, snd_irq, snd_nmi_l, snd_reset.
// Optional macro MBOX_NMI_EN: pulse snd_nmi_l low for NMI_CYCLES clocks on
// every accepted command push; otherwise snd_nmi_l is tied high.
module sound_mailbox_ctrl
    import sound_mbox_pkg::*;
#(
    parameter int M2S_DEPTH  = 4,
    parameter int RST_CYCLES = 16,
    parameter int NMI_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_wr,
    input  logic [DW-1:0] main_din,
    input  logic          main_rd,
    output logic [DW-1:0] main_dout,
    output logic          main_irq,
    input  logic          main_snd_rst,
    output logic [3:0]    main_status,
    input  logic          snd_rd68k,
    output logic [DW-1:0] snd_dout,
    input  logic          snd_wr68k,
    input  logic [DW-1:0] snd_din,
    output logic [2:0]    snd_status,
    output logic          snd_irq,
    output logic          snd_nmi_l,
    output logic          snd_reset
);
    localparam int RW = $clog2(RST_CYCLES + 1);

    if (M2S_DEPTH < 2 || (M2S_DEPTH & (M2S_DEPTH - 1)) != 0 || RST_CYCLES < 1 || NMI_CYCLES < 1) begin : g_bad_param
        $error("sound_mailbox_ctrl: illegal parameter value");
    end

    mbox_state_e   state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [DW-1:0] s2m_data_q, s2m_data_d;
    logic          s2m_full_q, s2m_full_d;
    logic          s2m_ovf_q, s2m_ovf_d;
    logic          m2s_ovf_q, m2s_ovf_d;

    logic          snd_run, pop_req, wr_req, pop_ok;
    logic          m2s_full, m2s_empty;
    logic [$clog2(M2S_DEPTH):0] m2s_count;

    // Sound-side strobes are meaningless while the sound CPU is held in reset.
    assign snd_run = (state_q == RUN);
    assign pop_req = snd_rd68k & snd_run;
    assign wr_req  = snd_wr68k & snd_run;
    assign pop_ok  = pop_req & ~m2s_empty;

    mbox_fifo #(.DEPTH(M2S_DEPTH), .W(DW)) u_m2s_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (main_wr),
        .pop   (pop_req),
        .flush (main_snd_rst),
        .din   (main_din),
        .dout  (snd_dout),
        .full  (m2s_full),
        .empty (m2s_empty),
        .count (m2s_count)
    );

    // Reset sequencer
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        if (main_snd_rst) begin
            state_d   = RST_HOLD;
            rst_cnt_d = RW'(RST_CYCLES);
        end else if (state_q == RST_HOLD) begin
            if (rst_cnt_q == RW'(1)) state_d = RUN;
            else                     rst_cnt_d = rst_cnt_q - RW'(1);
        end
    end

    // Flags and response latch; a reset request clears everything.
    always_comb begin
        s2m_data_d = s2m_data_q;
        s2m_full_d = s2m_full_q;
        s2m_ovf_d  = s2m_ovf_q;
        m2s_ovf_d  = m2s_ovf_q;
        if (main_snd_rst) begin
            s2m_data_d = '0;
            s2m_full_d = 1'b0;
            s2m_ovf_d  = 1'b0;
            m2s_ovf_d  = 1'b0;
        end else begin
            // A new overflow in the same cycle as main_rd is kept visible.
            if (main_wr && m2s_full && !pop_ok) m2s_ovf_d = 1'b1;
            else if (main_rd)                   m2s_ovf_d = 1'b0;

            if (wr_req) begin
                s2m_data_d = snd_din;
                s2m_full_d = 1'b1;
                // Overwrite counts as overflow only if the old byte is not being read now.
                if (s2m_full_q && !main_rd) s2m_ovf_d = 1'b1;
            end else if (main_rd) begin
                s2m_full_d = 1'b0;
                s2m_ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_HOLD;
            rst_cnt_q  <= RW'(RST_CYCLES);
            s2m_data_q <= '0;
            s2m_full_q <= 1'b0;
            s2m_ovf_q  <= 1'b0;
            m2s_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            s2m_data_q <= s2m_data_d;
            s2m_full_q <= s2m_full_d;
            s2m_ovf_q  <= s2m_ovf_d;
            m2s_ovf_q  <= m2s_ovf_d;
        end
    end

`ifdef MBOX_NMI_EN
    localparam int NW = $clog2(NMI_CYCLES + 1);
    logic [NW-1:0] nmi_cnt_q, nmi_cnt_d;
    logic          push_ok;

    assign push_ok = main_wr & (~m2s_full | pop_ok);

    always_comb begin
        nmi_cnt_d = nmi_cnt_q;
        if (main_snd_rst)          nmi_cnt_d = '0;
        else if (push_ok)          nmi_cnt_d = NW'(NMI_CYCLES);
        else if (nmi_cnt_q != '0)  nmi_cnt_d = nmi_cnt_q - NW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) nmi_cnt_q <= '0;
        else     nmi_cnt_q <= nmi_cnt_d;
    end

    // Pulses started by preloaded commands stay masked until release.
    assign snd_nmi_l = ~((nmi_cnt_q != '0) && snd_run);
`else
    assign snd_nmi_l = 1'b1;
`endif

    assign snd_reset = ~snd_run;
    assign main_dout = s2m_data_q;
    assign main_irq  = s2m_full_q;
    assign snd_irq   = (m2s_count != '0) & snd_run;

    always_comb begin
        main_status               = '0;
        main_status[MST_M2S_FULL] = m2s_full;
        main_status[MST_M2S_OVF]  = m2s_ovf_q;
        main_status[MST_S2M_FULL] = s2m_full_q;
        main_status[MST_RST_BUSY] = ~snd_run;
        snd_status                   = '0;
        snd_status[SST_M2S_NONEMPTY] = ~m2s_empty;
        snd_status[SST_S2M_FULL]     = s2m_full_q;
        snd_status[SST_S2M_OVF]      = s2m_ovf_q;
    end
endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
module tb_sound_mailbox_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       main_wr = 0, main_rd = 0, main_snd_rst = 0;
    logic [7:0] main_din = 0, snd_din = 0;
    logic       snd_rd68k = 0, snd_wr68k = 0;
    logic [7:0] main_dout, snd_dout;
    logic       main_irq, snd_irq, snd_nmi_l, snd_reset;
    logic [3:0] main_status;
    logic [2:0] snd_status;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboards: queued command bytes, pending response, model flags.
    logic [7:0] cmd_q[$];
    logic [7:0] rsp_q[$];
    logic       m_m2s_ovf = 0, m_s2m_ovf = 0;

    always #5 clk = ~clk;

    sound_mailbox_ctrl dut (
        .clk(clk), .rst(rst),
        .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
        .main_dout(main_dout), .main_irq(main_irq), .main_snd_rst(main_snd_rst),
        .main_status(main_status), .snd_rd68k(snd_rd68k), .snd_dout(snd_dout),
        .snd_wr68k(snd_wr68k), .snd_din(snd_din), .snd_status(snd_status),
        .snd_irq(snd_irq), .snd_nmi_l(snd_nmi_l), .snd_reset(snd_reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vectors rebuilt from the scoreboard (valid in RUN only).
    task automatic check_status(input string tag);
        logic s2m_full;
        s2m_full = (rsp_q.size() != 0);
        check({tag, ".main_status"}, main_status,
              {1'b0, s2m_full, m_m2s_ovf, (cmd_q.size() == DEPTH)});
        check({tag, ".snd_status"}, snd_status,
              {m_s2m_ovf, s2m_full, (cmd_q.size() != 0)});
        check({tag, ".snd_irq"}, snd_irq, cmd_q.size() != 0);
        check({tag, ".main_irq"}, main_irq, s2m_full);
    endtask

    task automatic push(input logic [7:0] b);
        main_wr = 1; main_din = b;
        if (cmd_q.size() < DEPTH) cmd_q.push_back(b);
        else m_m2s_ovf = 1;
        tick();
        main_wr = 0;
        $display("push %02h depth=%0d", b, cmd_q.size());
    endtask

    task automatic pop();
        logic [7:0] exp;
        exp = (cmd_q.size() != 0) ? cmd_q.pop_front() : 8'h00;
        check("pop.snd_dout", snd_dout, exp);
        snd_rd68k = 1;
        tick();
        snd_rd68k = 0;
        $display("pop  %02h depth=%0d", exp, cmd_q.size());
    endtask

    task automatic push_pop(input logic [7:0] b);
        logic [7:0] exp;
        exp = cmd_q.pop_front();
        cmd_q.push_back(b);
        check("pushpop.snd_dout", snd_dout, exp);
        main_wr = 1; main_din = b; snd_rd68k = 1;
        tick();
        main_wr = 0; snd_rd68k = 0;
        $display("push+pop in %02h out %02h depth=%0d", b, exp, cmd_q.size());
    endtask

    task automatic snd_write(input logic [7:0] b);
        if (rsp_q.size() != 0) begin
            m_s2m_ovf = 1;
            void'(rsp_q.pop_front());
        end
        rsp_q.push_back(b);
        snd_wr68k = 1; snd_din = b;
        tick();
        snd_wr68k = 0;
        check("snd_write.main_dout", main_dout, b);
        $display("snd_wr68k %02h", b);
    endtask

    task automatic main_read();
        logic [7:0] exp;
        exp = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
        check("main_read.main_dout", main_dout, exp);
        main_rd = 1;
        tick();
        main_rd = 0;
        m_m2s_ovf = 0; m_s2m_ovf = 0;
        check("main_read.dout_kept", main_dout, exp);
        $display("main_rd %02h", exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset and the initial sound-CPU hold
        repeat (20) @(posedge clk);
        #1 rst = 0;
        check("rst.snd_reset", snd_reset, 1'b1);
        check("rst.main_status", main_status, 4'b1000);
        check("rst.snd_status", snd_status, 3'b000);
        check("rst.main_irq", main_irq, 1'b0);
        check("rst.snd_irq", snd_irq, 1'b0);
        check("rst.snd_nmi_l", snd_nmi_l, 1'b1);
        check("rst.main_dout", main_dout, 8'h00);
        check("rst.snd_dout", snd_dout, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("rst.hold", snd_reset, 1'b1);
        end
        tick();
        check("rst.release", snd_reset, 1'b0);
        check_status("rst.run");
        $display("reset sequence done");

        // 2. Basic push/pop with show-ahead head
        push(8'hA1);
        push(8'hB2);
        check_status("t2.two");
        pop();
        pop();
        check("t2.empty_dout", snd_dout, 8'h00);
        check_status("t2.empty");
        pop();  // pop on empty is ignored
        check_status("t2.pop_empty");

        // 3. Overflow and push+pop while full
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        check_status("t3.ovf");
        push_pop(8'h15);
        check_status("t3.pushpop");
        for (int i = 0; i < 4; i++) pop();
        check_status("t3.drained");
        main_read();
        check_status("t3.ovf_clr");

        // 4. Response latch
        snd_write(8'h3C);
        check_status("t4.first");
        snd_write(8'h4D);
        check_status("t4.overwrite");
        main_read();
        check_status("t4.read");

        // 5. Sound-CPU reset with traffic queued
        push(8'h21); push(8'h22); push(8'h23);
        snd_write(8'h77);
        main_snd_rst = 1;
        tick();
        main_snd_rst = 0;
        cmd_q.delete(); rsp_q.delete(); m_m2s_ovf = 0; m_s2m_ovf = 0;
        $display("main_snd_rst");
        check("t5.snd_reset", snd_reset, 1'b1);
        check("t5.main_status", main_status, 4'b1000);
        check("t5.snd_status", snd_status, 3'b000);
        check("t5.snd_dout", snd_dout, 8'h00);
        check("t5.main_dout", main_dout, 8'h00);
        main_wr = 1; main_din = 8'h5A; cmd_q.push_back(8'h5A);
        tick();
        main_wr = 0;
        $display("push %02h during hold", 8'h5A);
        check("t5.hold_irq", snd_irq, 1'b0);
        check("t5.hold_nmi", snd_nmi_l, 1'b1);
        snd_rd68k = 1;
        tick();
        snd_rd68k = 0;
        $display("pop attempt during hold");
        for (int i = 0; i < 13; i++) begin
            tick();
            check("t5.hold", snd_reset, 1'b1);
        end
        tick();
        check("t5.release", snd_reset, 1'b0);
        check_status("t5.run");
        pop();
        check_status("t5.empty");

        // 6. NMI pulse and retrigger
`ifdef MBOX_NMI_EN
        push(8'h61);
        check("t6.nmi_c0", snd_nmi_l, 1'b0);
        tick();
        check("t6.nmi_c1", snd_nmi_l, 1'b0);
        push(8'h62);
        check("t6.nmi_c2", snd_nmi_l, 1'b0);
        for (int i = 3; i < 6; i++) begin
            tick();
            check("t6.nmi_ext", snd_nmi_l, 1'b0);
        end
        tick();
        check("t6.nmi_c6", snd_nmi_l, 1'b1);
`else
        push(8'h61);
        check("t6.nmi_c0", snd_nmi_l, 1'b1);
        tick();
        push(8'h62);
        check("t6.nmi_c2", snd_nmi_l, 1'b1);
        for (int i = 3; i < 7; i++) begin
            tick();
            check("t6.nmi_tied", snd_nmi_l, 1'b1);
        end
`endif
        pop();
        pop();
        check_status("t6.end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
